// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
// The master issues operands and start; the slave returns status and results.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (output start, a, b, input busy, done, diff, bout, ovf);
   modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell plus a
// registered borrow, LSB first, with results held until the next completion.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  sif
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic [WIDTH-2:0] r_sr;
   logic [WIDTH-1:0] r_full;
   logic [CW-1:0]    cnt;
   logic             br, a_msb, b_msb;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q, ovf_q;
   logic             ai, bi, d, br_nxt, last;

   // Signed overflow of a - b: operand signs differ and the result sign leaves a's.
   function automatic logic sub_ovf(input logic am, input logic bm, input logic dm);
      return (am != bm) && (dm != am);
   endfunction

   always_comb begin
      ai     = a_sr[0];
      bi     = b_sr[0];
      d      = ai ^ bi ^ br;
      br_nxt = (~ai & bi) | (~(ai ^ bi) & br);
      r_full = {d, r_sr};
      last   = (cnt == CW'(WIDTH - 1));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sif.start) state_nxt = SHIFT;
         SHIFT:   if (last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         r_sr   <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         diff_q <= '0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (sif.start) begin
                  a_sr  <= sif.a;
                  b_sr  <= sif.b;
                  a_msb <= sif.a[WIDTH-1];
                  b_msb <= sif.b[WIDTH-1];
                  br    <= 1'b0;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               // r_sr keeps the low WIDTH-1 result bits; the final bit joins on the last edge.
               a_sr <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr <= {1'b0, b_sr[WIDTH-1:1]};
               r_sr <= r_full[WIDTH-1:1];
               br   <= br_nxt;
               cnt  <= cnt + 1'b1;
               if (last) begin
                  diff_q <= r_full;
                  bout_q <= br_nxt;
                  ovf_q  <= sub_ovf(a_msb, b_msb, d);
               end
            end
            default: ;
         endcase
      end
   end

   assign sif.busy = (state != IDLE);
   assign sif.done = (state == DONE);
   assign sif.diff = diff_q;
   assign sif.bout = bout_q;
   assign sif.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8: latency, results, flags,
// ignored starts, async reset mid-operation and back-to-back throughput.
module tb_serial_subtractor;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   lat, bcnt, nd, t_prev, dcount;

   serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .sif (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one operation; optionally pulse a stray start at cycle pulse_k after accept.
   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input int pulse_k,
                         output int olat, output int obusy);
      @(negedge clk);
      bus.a = ia; bus.b = ib; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      olat = 0; obusy = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.busy) obusy++;
         if (k == pulse_k) begin bus.start = 1'b1; bus.a = 8'd3; bus.b = 8'd3; end
         if (k == pulse_k + 1) bus.start = 1'b0;
         if (bus.done) begin olat = k; break; end
      end
   endtask

   initial begin
      rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
      #12;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_diff", bus.diff, 0);
      chk("rst_bout", bus.bout, 0);
      chk("rst_ovf",  bus.ovf, 0);
      @(negedge clk); rst = 1'b0;

      // 100 - 37
      run_op(8'd100, 8'd37, 0, lat, bcnt);
      chk("t1_latency", lat, 9);
      chk("t1_busy_cycles", bcnt, 9);
      chk("t1_diff", bus.diff, 63);
      chk("t1_bout", bus.bout, 0);
      chk("t1_ovf",  bus.ovf, 0);
      @(negedge clk);
      chk("t1_done_pulse", bus.done, 0);
      chk("t1_busy_after", bus.busy, 0);

      // 5 - 10, then hold through idle with operands changing
      run_op(8'd5, 8'd10, 0, lat, bcnt);
      chk("t2_diff", bus.diff, 8'hFB);
      chk("t2_bout", bus.bout, 1);
      chk("t2_ovf",  bus.ovf, 0);
      bus.a = 8'h12; bus.b = 8'h34;
      repeat (5) @(negedge clk);
      chk("t2_hold_diff", bus.diff, 8'hFB);
      chk("t2_hold_bout", bus.bout, 1);

      // Signed overflow both directions
      run_op(8'h80, 8'h01, 0, lat, bcnt);
      chk("t3a_diff", bus.diff, 8'h7F);
      chk("t3a_bout", bus.bout, 0);
      chk("t3a_ovf",  bus.ovf, 1);
      run_op(8'h7F, 8'hFF, 0, lat, bcnt);
      chk("t3b_diff", bus.diff, 8'h80);
      chk("t3b_bout", bus.bout, 1);
      chk("t3b_ovf",  bus.ovf, 1);

      // Boundary: b = 0 and a = b
      run_op(8'h5A, 8'h00, 0, lat, bcnt);
      chk("b0_diff", bus.diff, 8'h5A);
      chk("b0_bout", bus.bout, 0);
      chk("b0_ovf",  bus.ovf, 0);
      run_op(8'hC3, 8'hC3, 0, lat, bcnt);
      chk("eq_diff", bus.diff, 0);
      chk("eq_bout", bus.bout, 0);

      // Stray start during the 4th SHIFT cycle is ignored
      run_op(8'd200, 8'd1, 4, lat, bcnt);
      chk("t4_latency", lat, 9);
      chk("t4_busy_cycles", bcnt, 9);
      chk("t4_diff", bus.diff, 199);
      @(negedge clk);
      chk("t4_no_requeue_busy", bus.busy, 0);
      chk("t4_no_requeue_done", bus.done, 0);
      chk("t4_diff_hold", bus.diff, 199);

      // Async reset in the 5th SHIFT cycle of 9 - 4
      @(negedge clk);
      bus.a = 8'd9; bus.b = 8'd4; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (5) @(negedge clk);
      chk("t5_busy_before", bus.busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_busy", bus.busy, 0);
      chk("t5_rst_done", bus.done, 0);
      chk("t5_rst_diff", bus.diff, 0);
      chk("t5_rst_bout", bus.bout, 0);
      chk("t5_rst_ovf",  bus.ovf, 0);
      @(negedge clk); rst = 1'b0;
      dcount = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (bus.done || bus.busy) dcount++;
      end
      chk("t5_no_done_after_rst", dcount, 0);
      run_op(8'd9, 8'd4, 0, lat, bcnt);
      chk("t5_latency", lat, 9);
      chk("t5_diff", bus.diff, 5);

      // start held high: 0-0, 0-1, 255-255
      @(negedge clk);
      bus.a = 8'd0; bus.b = 8'd0; bus.start = 1'b1;
      nd = 0; t_prev = 0;
      for (int k = 1; k <= 60 && nd < 3; k++) begin
         @(negedge clk);
         if (bus.done) begin
            nd++;
            if (nd > 1) chk("t6_spacing", k - t_prev, 10);
            t_prev = k;
            if (nd == 1) begin
               chk("t6_r1_diff", bus.diff, 0);
               chk("t6_r1_bout", bus.bout, 0);
               bus.a = 8'd0; bus.b = 8'd1;
            end else if (nd == 2) begin
               chk("t6_r2_diff", bus.diff, 8'hFF);
               chk("t6_r2_bout", bus.bout, 1);
               chk("t6_r2_ovf",  bus.ovf, 0);
               bus.a = 8'd255; bus.b = 8'd255;
            end else begin
               chk("t6_r3_diff", bus.diff, 0);
               chk("t6_r3_bout", bus.bout, 0);
               bus.start = 1'b0;
            end
         end
      end
      chk("t6_count", nd, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
